// File: rtl/result_requant_wb_if.sv
// Bundle of the control, results-SRAM read and unified-buffer write
// signals of the result requantize/writeback engine.
interface result_requant_wb_if #(
  parameter int ADDRESSSIZE    = 10,
  parameter int MATRIX_SIZE    = 32,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int DATA_BW        = 8
);
  // job control
  logic                                start;
  logic [ADDRESSSIZE-1:0]              src_addr;
  logic [ADDRESSSIZE-1:0]              dst_addr;
  logic [ADDRESSSIZE:0]                num_rows;
  logic [3:0]                          shift;
  logic                                relu_en;
  logic                                busy;
  logic                                done;
  // results SRAM read port
  logic                                res_rd_en;
  logic [ADDRESSSIZE-1:0]              res_rd_addr;
  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] res_rd_data;
  // unified buffer write port
  logic                                ub_wr_en;
  logic [ADDRESSSIZE-1:0]              ub_wr_addr;
  logic [DATA_BW*MATRIX_SIZE-1:0]      ub_wr_data;
  logic                                ub_wr_ready;

  // the writeback engine
  modport slave (
    input  start, src_addr, dst_addr, num_rows, shift, relu_en,
    input  res_rd_data, ub_wr_ready,
    output busy, done, res_rd_en, res_rd_addr, ub_wr_en, ub_wr_addr, ub_wr_data
  );

  // the side that issues jobs and owns both memories
  modport master (
    output start, src_addr, dst_addr, num_rows, shift, relu_en,
    output res_rd_data, ub_wr_ready,
    input  busy, done, res_rd_en, res_rd_addr, ub_wr_en, ub_wr_addr, ub_wr_data
  );
endinterface

// File: rtl/result_requant_wb.sv
// Result requantize/writeback engine: reads wide partial-sum rows from the
// results SRAM, applies ReLU, rounding right shift and saturation per lane,
// and writes the packed narrow rows into the unified buffer.
module result_requant_wb #(
  parameter int ADDRESSSIZE    = 10,
  parameter int MATRIX_SIZE    = 32,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int DATA_BW        = 8
) (
  input  logic                clk,
  input  logic                rstn,
  result_requant_wb_if.slave  bus
);

  localparam int PSB = PARTIAL_SUM_BW;

  // Saturation bounds, sign-extended to the one-bit-wider arithmetic width.
  localparam logic signed [PSB:0] SAT_MAX =
    $signed({{(PSB-DATA_BW+2){1'b0}}, {(DATA_BW-1){1'b1}}});
  localparam logic signed [PSB:0] SAT_MIN =
    $signed({{(PSB-DATA_BW+2){1'b1}}, {(DATA_BW-1){1'b0}}});
  localparam logic [PSB:0] W_ONE = {{PSB{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    DONE
  } state_t;

  state_t                          r_state;
  logic [ADDRESSSIZE-1:0]          r_src;
  logic [ADDRESSSIZE-1:0]          r_dst;
  logic [ADDRESSSIZE:0]            r_num_rows;
  logic [ADDRESSSIZE:0]            r_idx;
  logic [3:0]                      r_shift;
  logic                            r_relu_en;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_res_rd_en;
  logic [ADDRESSSIZE-1:0]          r_res_rd_addr;
  logic                            r_ub_wr_en;
  logic [ADDRESSSIZE-1:0]          r_ub_wr_addr;
  logic [DATA_BW*MATRIX_SIZE-1:0]  r_ub_wr_data;

  logic [ADDRESSSIZE:0]            w_idx_inc;
  logic [DATA_BW*MATRIX_SIZE-1:0]  w_quant;

  assign w_idx_inc = r_idx + {{ADDRESSSIZE{1'b0}}, 1'b1};

  // Half-LSB rounding constant for the current shift; zero when shift is 0.
  logic signed [PSB:0] w_bias;
  assign w_bias = $signed((W_ONE << r_shift) >> 1);

  // Per-lane quantizer. Arithmetic runs one bit wider than the lane so the
  // rounding add can never overflow, even for the most positive input.
  genvar gi;
  generate
    for (gi = 0; gi < MATRIX_SIZE; gi++) begin : g_lane
      logic signed [PSB-1:0] w_lane;
      logic signed [PSB:0]   w_relu;
      logic signed [PSB:0]   w_sum;
      logic signed [PSB:0]   w_shr;
      logic [DATA_BW-1:0]    w_sat;

      assign w_lane = $signed(bus.res_rd_data[PSB*gi +: PSB]);
      assign w_relu = (r_relu_en && w_lane[PSB-1]) ? '0 : {w_lane[PSB-1], w_lane};
      assign w_sum  = w_relu + w_bias;
      assign w_shr  = w_sum >>> r_shift;
      assign w_sat  = (w_shr > SAT_MAX) ? SAT_MAX[DATA_BW-1:0] :
                      (w_shr < SAT_MIN) ? SAT_MIN[DATA_BW-1:0] :
                                          w_shr[DATA_BW-1:0];
      assign w_quant[DATA_BW*gi +: DATA_BW] = w_sat;
    end
  endgenerate

  // Job sequencer: one read, one quantize, one (possibly stalled) write per row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_src         <= '0;
      r_dst         <= '0;
      r_num_rows    <= '0;
      r_idx         <= '0;
      r_shift       <= '0;
      r_relu_en     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_res_rd_en   <= 1'b0;
      r_res_rd_addr <= '0;
      r_ub_wr_en    <= 1'b0;
      r_ub_wr_addr  <= '0;
      r_ub_wr_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.num_rows != '0) begin
              r_src         <= bus.src_addr;
              r_dst         <= bus.dst_addr;
              r_num_rows    <= bus.num_rows;
              r_shift       <= bus.shift;
              r_relu_en     <= bus.relu_en;
              r_idx         <= '0;
              r_res_rd_en   <= 1'b1;
              r_res_rd_addr <= bus.src_addr;
              r_state       <= RD;
            end else begin
              // empty job: no memory traffic, just the completion pulse
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        RD: begin
          // read strobe lasts exactly one cycle; data arrives during WAIT
          r_res_rd_en <= 1'b0;
          r_state     <= WAIT;
        end
        WAIT: begin
          r_ub_wr_data <= w_quant;
          r_ub_wr_en   <= 1'b1;
          r_ub_wr_addr <= r_dst + r_idx[ADDRESSSIZE-1:0];
          r_state      <= WR;
        end
        WR: begin
          // write outputs hold unchanged until the buffer accepts them
          if (bus.ub_wr_ready) begin
            r_ub_wr_en <= 1'b0;
            r_idx      <= w_idx_inc;
            if (w_idx_inc == r_num_rows) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_res_rd_en   <= 1'b1;
              r_res_rd_addr <= r_src + w_idx_inc[ADDRESSSIZE-1:0];
              r_state       <= RD;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_res_rd_en <= 1'b0;
          r_ub_wr_en  <= 1'b0;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.res_rd_en   = r_res_rd_en;
  assign bus.res_rd_addr = r_res_rd_addr;
  assign bus.ub_wr_en    = r_ub_wr_en;
  assign bus.ub_wr_addr  = r_ub_wr_addr;
  assign bus.ub_wr_data  = r_ub_wr_data;

endmodule

// File: tb/tb_result_requant_wb.sv
// Directed bench for result_requant_wb: table of quantization vectors run as
// single-row jobs, plus hand-written sequences for timing, stalls, address
// wrap, empty jobs, ignored starts and mid-job reset.
module tb_result_requant_wb;

  localparam int AS  = 10;
  localparam int MS  = 32;
  localparam int PSB = 24;
  localparam int DBW = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  result_requant_wb_if #(.ADDRESSSIZE(AS), .MATRIX_SIZE(MS),
                         .PARTIAL_SUM_BW(PSB), .DATA_BW(DBW)) bus ();

  result_requant_wb #(.ADDRESSSIZE(AS), .MATRIX_SIZE(MS),
                      .PARTIAL_SUM_BW(PSB), .DATA_BW(DBW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // results SRAM model: one-cycle read latency
  logic [PSB*MS-1:0] sram [0:(1<<AS)-1];
  always @(posedge clk) if (bus.res_rd_en) bus.res_rd_data <= sram[bus.res_rd_addr];

  // activity recorded each cycle
  int                rd_q[$];
  int                wr_q[$];
  int                done_q[$];
  logic [DBW*MS-1:0] wd_q[$];
  bit                overlap = 1'b0;

  // write-ready stall control
  int                stall_left = 0;
  bit                stall_cap = 1'b0;
  logic [AS-1:0]     cap_addr;
  logic [DBW*MS-1:0] cap_data;

  // Drive ready, check held write outputs while stalled, log bus activity.
  always @(negedge clk) begin
    if (stall_left > 0 && bus.ub_wr_en) begin
      if (!stall_cap) begin
        stall_cap = 1'b1;
        cap_addr  = bus.ub_wr_addr;
        cap_data  = bus.ub_wr_data;
      end else begin
        tests++;
        if (bus.ub_wr_addr !== cap_addr || bus.ub_wr_data !== cap_data) begin
          fails++;
          $display("FAIL stall_hold addr=%0d data=%h required addr=%0d data=%h",
                   bus.ub_wr_addr, bus.ub_wr_data, cap_addr, cap_data);
        end
      end
      stall_left--;
      bus.ub_wr_ready = 1'b0;
    end else begin
      bus.ub_wr_ready = 1'b1;
    end
    if (bus.res_rd_en) rd_q.push_back(int'(bus.res_rd_addr));
    if (bus.ub_wr_en && bus.ub_wr_ready) begin
      wr_q.push_back(int'(bus.ub_wr_addr));
      wd_q.push_back(bus.ub_wr_data);
    end
    if (bus.done) done_q.push_back(cyc);
    if (bus.res_rd_en && bus.ub_wr_en) overlap = 1'b1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Run one job; cycle 1 is the cycle right after the edge that samples start.
  task automatic run_job(input int src, input int dst, input int n, input int sh,
                         input int relu, input int stall, input bit glitch,
                         input int exp_done);
    int c0;
    int t;
    rd_q.delete(); wr_q.delete(); wd_q.delete(); done_q.delete();
    overlap    = 1'b0;
    stall_cap  = 1'b0;
    stall_left = stall;
    bus.src_addr = AS'(src);
    bus.dst_addr = AS'(dst);
    bus.num_rows = (AS+1)'(n);
    bus.shift    = 4'(sh);
    bus.relu_en  = relu[0];
    bus.start    = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    bus.start = 1'b0;
    chk("busy_after_start", int'(bus.busy), 1);
    t = 0;
    while (done_q.size() == 0 && t < 300) begin
      if (glitch && t == 0) begin
        // start with different parameters while busy: must be ignored
        bus.start    = 1'b1;
        bus.src_addr = AS'(900);
        bus.dst_addr = AS'(600);
        bus.num_rows = (AS+1)'(5);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      t++;
    end
    bus.start = 1'b0;
    chk("done_seen", done_q.size(), 1);
    if (done_q.size() > 0) chk("done_cycle", done_q[0] - c0 + 1, exp_done);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_q.size(), 1);
    chk("busy_end", int'(bus.busy), 0);
    chk("rd_count", rd_q.size(), n);
    chk("wr_count", wr_q.size(), n);
    for (int i = 0; i < n && i < rd_q.size(); i++) chk("rd_addr", rd_q[i], (src + i) % (1 << AS));
    for (int i = 0; i < n && i < wr_q.size(); i++) chk("wr_addr", wr_q[i], (dst + i) % (1 << AS));
    chk("rd_wr_overlap", int'(overlap), 0);
  endtask

  typedef struct {
    int l0, l1, l2, l3;
    int sh;
    int relu;
    int e0, e1, e2, e3;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [PSB*MS-1:0] row;
    logic [DBW*MS-1:0] wd;
    int lv[4];
    int ev[4];
    int t;

    vecs[0] = '{300, -300, 127, -128,              0, 0, 127, -128, 127, -128};
    vecs[1] = '{300, -300, 127, -128,              2, 0,  75,  -75,  32,  -32};
    vecs[2] = '{-40, 6, 5, -40,                    0, 1,   0,    6,   5,    0};
    vecs[3] = '{-40, 6, 5, 7,                      2, 0, -10,    2,   1,    2};
    vecs[4] = '{5, -5, 3, 1,                       1, 0,   3,   -2,   2,    1};
    vecs[5] = '{8388607, -8388608, 32767, -32768, 15, 0, 127, -128,   1,   -1};
    vecs[6] = '{-1000, 1000, -1, 255,              3, 1,   0,  125,   0,   32};
    vecs[7] = '{128, -129, -1, 0,                  0, 0, 127, -128,  -1,    0};

    // every row carries its own index in lane 0
    for (int i = 0; i < (1 << AS); i++) sram[i] = {{(PSB*MS-PSB){1'b0}}, 24'(i)};

    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.num_rows = '0;
    bus.shift = '0;   bus.relu_en = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_rd_en", int'(bus.res_rd_en), 0);
    chk("rst_wr_en", int'(bus.ub_wr_en), 0);
    chk("rst_rd_addr", int'(bus.res_rd_addr), 0);
    chk("rst_wr_addr", int'(bus.ub_wr_addr), 0);
    chk("rst_wr_data_zero", int'(bus.ub_wr_data == '0), 1);
    rstn = 1'b1;
    @(posedge clk); #1;

    // basic 3-row job, ready always high: done in cycle 10
    run_job(5, 100, 3, 0, 0, 0, 1'b0, 10);
    for (int i = 0; i < 3 && i < wd_q.size(); i++) begin
      wd = wd_q[i];
      chk("job_a_lane0", int'(wd[7:0]), 5 + i);
    end

    // quantization table, one single-row job per vector
    for (int k = 0; k < 8; k++) begin
      lv = '{vecs[k].l0, vecs[k].l1, vecs[k].l2, vecs[k].l3};
      ev = '{vecs[k].e0, vecs[k].e1, vecs[k].e2, vecs[k].e3};
      row = '0;
      for (int l = 0; l < 4; l++) row[PSB*l +: PSB] = PSB'(lv[l]);
      sram[200 + k] = row;
      run_job(200 + k, 300 + k, 1, vecs[k].sh, vecs[k].relu, 0, 1'b0, 4);
      if (wd_q.size() > 0) begin
        wd = wd_q[0];
        for (int l = 0; l < 4; l++) begin
          tests++;
          if (int'($signed(wd[DBW*l +: DBW])) != ev[l]) begin
            fails++;
            $display("FAIL vec%0d_lane%0d got=%0d expected=%0d", k, l,
                     int'($signed(wd[DBW*l +: DBW])), ev[l]);
          end
        end
        chk("vec_upper_lanes_zero", int'(wd[DBW*MS-1:32] == '0), 1);
      end
      $display("[TB] vector %0d shift=%0d relu=%0d done", k, vecs[k].sh, vecs[k].relu);
    end

    // ready held low for 4 cycles in the first write: 4 cycles late
    run_job(20, 40, 2, 0, 0, 4, 1'b0, 11);

    // address wrap plus an ignored start while busy
    run_job(1023, 1022, 2, 0, 0, 0, 1'b1, 7);

    // empty job plus a start during its DONE cycle
    run_job(50, 60, 0, 0, 0, 0, 1'b1, 1);

    // reset during WAIT of row 1 of a 3-row job
    rd_q.delete(); wr_q.delete(); wd_q.delete(); done_q.delete();
    stall_left = 0;
    bus.src_addr = AS'(30); bus.dst_addr = AS'(70); bus.num_rows = (AS+1)'(3);
    bus.shift = 4'd0; bus.relu_en = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    t = 0;
    while (rd_q.size() < 2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("mid_reset_reached_row1", rd_q.size(), 2);
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_rd_en", int'(bus.res_rd_en), 0);
    chk("mid_rst_wr_en", int'(bus.ub_wr_en), 0);
    chk("mid_rst_rd_addr", int'(bus.res_rd_addr), 0);
    chk("mid_rst_wr_addr", int'(bus.ub_wr_addr), 0);
    chk("mid_rst_wr_data_zero", int'(bus.ub_wr_data == '0), 1);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_writes", wr_q.size(), 1);
    chk("mid_rst_no_done", done_q.size(), 0);
    run_job(30, 70, 3, 0, 0, 0, 1'b0, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
